// File: rtl/seq_divider16.sv
// seq_divider16: unsigned restoring divider producing one quotient bit per clock
module seq_divider16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] part, part_n, dvd, dvd_n, dsr;
  logic [WIDTH:0] shifted, diff;
  logic q_bit, last, accept;
  always_comb begin
    shifted = {part, dvd[WIDTH-1]};
    diff = shifted - {1'b0, dsr};
    q_bit = ~diff[WIDTH];
    part_n = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    dvd_n = {dvd[WIDTH-2:0], q_bit};
    last = cnt == CW'(WIDTH - 1);
    accept = state == IDLE && start;
    state_n = state == IDLE ? (start ? (divisor == '0 ? DONE : RUN) : IDLE)
            : state == RUN ? (last ? DONE : RUN)
            : IDLE;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt <= '0;
      part <= '0;
      dvd <= '0;
      dsr <= '0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else begin
      busy <= state_n != IDLE;
      done <= state_n == DONE;
      if (accept) begin
        dvd <= dividend;
        dsr <= divisor;
        part <= '0;
        cnt <= '0;
        if (divisor == '0) begin
          quotient <= '1;
          remainder <= dividend;
          div_by_zero <= 1'b1;
        end
      end
      if (state == RUN) begin
        part <= part_n;
        dvd <= dvd_n;
        cnt <= cnt + 1'b1;
        if (last) begin
          quotient <= dvd_n;
          remainder <= part_n;
          div_by_zero <= 1'b0;
        end
      end
    end
  end
endmodule
